// File: rtl/count_seq_if.sv
// Bundles the observed-counter inputs and the checker status outputs.
// master drives the sampled counter and controls; slave is the checker.
interface count_seq_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             en;
  logic [WIDTH-1:0] count_in;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic             err_sticky;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

  modport master (
    output en, count_in, clr_err,
    input  locked, err_pulse, err_sticky, err_count, expected
  );

  modport slave (
    input  en, count_in, clr_err,
    output locked, err_pulse, err_sticky, err_count, expected
  );
endinterface

// File: rtl/count_seq_checker.sv
// Monitor for a free-running up-counter: locks after LOCK_LEN clean increments,
// then reports every step that is not +1 (mod 2^WIDTH) as an error.
module count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8
) (
  input logic        clk,
  input logic        rst,
  count_seq_if.slave bus
);
  localparam int RUN_W = $clog2(LOCK_LEN + 1);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               err_pulse_q, err_pulse_d;
  logic               err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  logic [WIDTH-1:0]   expected_w;
  logic [RUN_W-1:0]   run_inc;
  logic               match;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign expected_w = prev_q + WIDTH'(1);
  assign match      = (bus.count_in == expected_w);
  assign run_inc    = run_q + RUN_W'(1);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    run_d        = run_q;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;

    if (bus.clr_err) begin
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end

    if (!bus.en) begin
      state_d = IDLE;
      run_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          prev_d  = bus.count_in;
          run_d   = '0;
          state_d = ACQ;
        end
        ACQ: begin
          prev_d = bus.count_in;
          if (match) begin
            if (run_inc == RUN_W'(LOCK_LEN)) begin
              run_d   = '0;
              state_d = LOCKED;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          prev_d = bus.count_in;
          if (!match) begin
            // A concurrent clr_err is overridden: counting starts again from the cleared value.
            err_pulse_d  = 1'b1;
            err_sticky_d = 1'b1;
            err_count_d  = sat_inc(bus.clr_err ? '0 : err_count_q);
            run_d        = '0;
            state_d      = ACQ;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_q       <= '0;
      run_q        <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      run_q        <= run_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.locked     = (state_q == LOCKED);
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_count  = err_count_q;
  assign bus.expected   = expected_w;
endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench: a default checker (ERR_W=8) and a narrow one (ERR_W=2) see the same stimulus.
module tb_count_seq_checker;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr_err;
  logic [3:0] cnt;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  count_seq_if #(.WIDTH(4), .ERR_W(8)) bus ();
  count_seq_if #(.WIDTH(4), .ERR_W(2)) bus_s ();

  assign bus.en         = en;
  assign bus.count_in   = cnt;
  assign bus.clr_err    = clr_err;
  assign bus_s.en       = en;
  assign bus_s.count_in = cnt;
  assign bus_s.clr_err  = clr_err;

  count_seq_checker #(.WIDTH(4), .LOCK_LEN(3), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  count_seq_checker #(.WIDTH(4), .LOCK_LEN(3), .ERR_W(2)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; clr_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cnt = (i == 0) ? 4'd5 : 4'd10;
      step();
      total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%0b want=0", bus.locked); end
      total++; if (bus.err_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%0b want=0", bus.err_pulse); end
      total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%0b want=0", bus.err_sticky); end
      total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.err_count); end
      total++; if (bus.expected !== 4'd1) begin bad++; $display("FAIL reset_expected got=%0d want=1", bus.expected); end
      total++; if (bus_s.err_count !== 2'd0) begin bad++; $display("FAIL reset_count_s got=%0d want=0", bus_s.err_count); end
    end
    rst = 1'b0;
  endtask

  task automatic test_acquire;
    for (int i = 0; i <= 4; i++) begin
      cnt = 4'(i);
      step();
      if (i == 2) begin
        total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL acq_early got=%0b want=0", bus.locked); end
      end
      if (i >= 3) begin
        total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL acq_locked s=%0d got=%0b want=1", i, bus.locked); end
      end
    end
    total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL acq_count got=%0d want=0", bus.err_count); end
    total++; if (bus.expected !== 4'd5) begin bad++; $display("FAIL acq_expected got=%0d want=5", bus.expected); end
  endtask

  task automatic test_wrap;
    for (int i = 5; i <= 17; i++) begin
      cnt = 4'(i);
      step();
      if (i >= 13) begin
        total++; if (bus.err_pulse !== 1'b0) begin bad++; $display("FAIL wrap_pulse s=%0d got=%0b want=0", cnt, bus.err_pulse); end
        total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL wrap_locked s=%0d got=%0b want=1", cnt, bus.locked); end
      end
      if (i == 15) begin
        total++; if (bus.expected !== 4'd0) begin bad++; $display("FAIL wrap_expected got=%0d want=0", bus.expected); end
      end
    end
  endtask

  task automatic test_skip_error;
    logic [3:0] seq [10];
    seq = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};
    for (int i = 0; i < 10; i++) begin
      cnt = seq[i];
      step();
      if (cnt == 4'd8) begin
        total++; if (bus.err_pulse !== 1'b1) begin bad++; $display("FAIL skip_pulse got=%0b want=1", bus.err_pulse); end
        total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL skip_count got=%0d want=1", bus.err_count); end
        total++; if (bus.err_sticky !== 1'b1) begin bad++; $display("FAIL skip_sticky got=%0b want=1", bus.err_sticky); end
        total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL skip_unlock got=%0b want=0", bus.locked); end
      end
      if (cnt == 4'd9) begin
        total++; if (bus.err_pulse !== 1'b0) begin bad++; $display("FAIL skip_pulse_width got=%0b want=0", bus.err_pulse); end
      end
      if (cnt == 4'd10) begin
        total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL skip_relock_early got=%0b want=0", bus.locked); end
      end
      if (cnt == 4'd11 || cnt == 4'd12) begin
        total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL skip_relock s=%0d got=%0b want=1", cnt, bus.locked); end
      end
    end
    total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL skip_count_hold got=%0d want=1", bus.err_count); end
  endtask

  task automatic test_saturation_clear;
    logic [3:0] v;
    v = 4'd12;
    for (int k = 1; k <= 5; k++) begin
      v = v + 4'd2;
      cnt = v;
      step();
      total++; if (bus_s.err_pulse !== 1'b1) begin bad++; $display("FAIL sat_pulse k=%0d got=%0b want=1", k, bus_s.err_pulse); end
      total++; if (bus_s.err_count !== ((k + 1 > 3) ? 2'd3 : 2'(k + 1))) begin bad++; $display("FAIL sat_count k=%0d got=%0d want=%0d", k, bus_s.err_count, (k + 1 > 3) ? 3 : k + 1); end
      total++; if (bus.err_count !== 8'(k + 1)) begin bad++; $display("FAIL wide_count k=%0d got=%0d want=%0d", k, bus.err_count, k + 1); end
      for (int j = 0; j < 3; j++) begin
        v = v + 4'd1;
        cnt = v;
        step();
      end
      total++; if (bus_s.locked !== 1'b1) begin bad++; $display("FAIL sat_relock k=%0d got=%0b want=1", k, bus_s.locked); end
    end
    clr_err = 1'b1;
    v = v + 4'd1;
    cnt = v;
    step();
    clr_err = 1'b0;
    total++; if (bus_s.err_count !== 2'd0) begin bad++; $display("FAIL clr_count got=%0d want=0", bus_s.err_count); end
    total++; if (bus_s.err_sticky !== 1'b0) begin bad++; $display("FAIL clr_sticky got=%0b want=0", bus_s.err_sticky); end
    total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL clr_count_w got=%0d want=0", bus.err_count); end
    total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL clr_locked got=%0b want=1", bus.locked); end
    clr_err = 1'b1;
    v = v + 4'd3;
    cnt = v;
    step();
    clr_err = 1'b0;
    total++; if (bus_s.err_count !== 2'd1) begin bad++; $display("FAIL clr_err_count got=%0d want=1", bus_s.err_count); end
    total++; if (bus_s.err_sticky !== 1'b1) begin bad++; $display("FAIL clr_err_sticky got=%0b want=1", bus_s.err_sticky); end
    total++; if (bus_s.err_pulse !== 1'b1) begin bad++; $display("FAIL clr_err_pulse got=%0b want=1", bus_s.err_pulse); end
    total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL clr_err_count_w got=%0d want=1", bus.err_count); end
    for (int j = 0; j < 3; j++) begin
      v = v + 4'd1;
      cnt = v;
      step();
    end
    total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL clr_relock got=%0b want=1", bus.locked); end
  endtask

  task automatic test_reset_and_enable;
    rst = 1'b1;
    cnt = cnt + 4'd1;
    step();
    rst = 1'b0;
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL mid_rst_locked got=%0b want=0", bus.locked); end
    total++; if (bus.err_pulse !== 1'b0) begin bad++; $display("FAIL mid_rst_pulse got=%0b want=0", bus.err_pulse); end
    total++; if (bus.err_sticky !== 1'b0) begin bad++; $display("FAIL mid_rst_sticky got=%0b want=0", bus.err_sticky); end
    total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL mid_rst_count got=%0d want=0", bus.err_count); end
    total++; if (bus.expected !== 4'd1) begin bad++; $display("FAIL mid_rst_expected got=%0d want=1", bus.expected); end
    for (int i = 0; i <= 3; i++) begin
      cnt = 4'(i);
      step();
    end
    total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL en_relock got=%0b want=1", bus.locked); end
    cnt = 4'd5;
    step();
    for (int i = 6; i <= 8; i++) begin
      cnt = 4'(i);
      step();
    end
    total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL en_relock2 got=%0b want=1", bus.locked); end
    en = 1'b0;
    cnt = 4'd9;
    step();
    total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL en_drop_locked got=%0b want=0", bus.locked); end
    total++; if (bus.err_count !== 8'd1) begin bad++; $display("FAIL en_drop_count got=%0d want=1", bus.err_count); end
    total++; if (bus.err_sticky !== 1'b1) begin bad++; $display("FAIL en_drop_sticky got=%0b want=1", bus.err_sticky); end
    total++; if (bus.err_pulse !== 1'b0) begin bad++; $display("FAIL en_drop_pulse got=%0b want=0", bus.err_pulse); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; cnt = 4'd0;
    test_reset();
    test_acquire();
    test_wrap();
    test_skip_error();
    test_saturation_clear();
    test_reset_and_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
